bcd_int: RTL and testbench



---
 rtl/bcd_int.sv | 115 +++++++++++
 tb/tb_bcd_int.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_int.sv
// Iterative 4-digit BCD to 14-bit binary converter (reverse double-dabble, one bit per clock).
// Define BCD_INT_CHECK_EN to reject non-decimal digits; otherwise such digits are clamped to 9.
module bcd_int (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd,
    input  logic        convert,
    output logic [13:0] num,
    output logic        conv_done,
    output logic        error,
    output logic        busy
);

    typedef enum logic {IDLE, CONV} state_t;

    state_t      state_q, state_d;
    logic [29:0] sr_q, sr_d;
    logic [29:0] t;
    logic [3:0]  i_q, i_d;
    logic [13:0] num_q, num_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] bcd_acc;

`ifdef BCD_INT_CHECK_EN
    logic bcd_bad;

    always_comb begin
        bcd_bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (bcd[4*k +: 4] > 4'd9) bcd_bad = 1'b1;
        end
        bcd_acc = bcd;
    end
`else
    always_comb begin
        bcd_acc = bcd;
        for (int k = 0; k < 4; k++) begin
            if (bcd[4*k +: 4] > 4'd9) bcd_acc[4*k +: 4] = 4'd9;
        end
    end
`endif

    // A digit LSB shifted into the digit below lands with weight 8 but means 5, hence -3.
    always_comb begin
        t = sr_q >> 1;
        for (int k = 0; k < 4; k++) begin
            if (t[14 + 4*k + 3]) t[14 + 4*k +: 4] = t[14 + 4*k +: 4] - 4'd3;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        i_d     = i_q;
        num_d   = num_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (convert) begin
`ifdef BCD_INT_CHECK_EN
                    if (bcd_bad) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        sr_d    = {bcd_acc, 14'b0};
                        i_d     = 4'd0;
                        state_d = CONV;
                    end
`else
                    sr_d    = {bcd_acc, 14'b0};
                    i_d     = 4'd0;
                    state_d = CONV;
`endif
                end
            end
            CONV: begin
                sr_d = t;
                i_d  = i_q + 4'd1;
                if (i_q == 4'd13) begin
                    num_d   = t[13:0];
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            i_q     <= '0;
            num_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            i_q     <= i_d;
            num_q   <= num_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign num       = num_q;
    assign conv_done = done_q;
    assign error     = err_q;
    assign busy      = (state_q == CONV);

endmodule

// File: tb/tb_bcd_int.sv
// Self-checking bench for bcd_int: vector table, multi-cycle corner sequences, randomized requests.
module tb_bcd_int;

    logic        clk;
    logic        rst;
    logic [15:0] bcd;
    logic        convert;
    logic [13:0] num;
    logic        conv_done;
    logic        error;
    logic        busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int model_num = 0;

    bcd_int dut (
        .clk       (clk),
        .rst       (rst),
        .bcd       (bcd),
        .convert   (convert),
        .num       (num),
        .conv_done (conv_done),
        .error     (error),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] b;
        logic [13:0] exp_num;
        logic        exp_err;
    } vec_t;

    vec_t tab[8];

    task automatic chk(input string nm, input int act, input int exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        else pass_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: decimal value of the digits; bad digit -> error (check on) or clamp to 9.
    task automatic model(input logic [15:0] b, output int en, output bit ee);
        int v;
        bit bad;
        v   = 0;
        bad = 0;
        for (int k = 3; k >= 0; k--) begin
            int d;
            d = int'(b[4*k +: 4]);
            if (d > 9) begin
                bad = 1;
                d   = 9;
            end
            v = v * 10 + d;
        end
`ifdef BCD_INT_CHECK_EN
        if (bad) begin
            en = model_num;
            ee = 1;
        end else begin
            model_num = v;
            en = v;
            ee = 0;
        end
`else
        model_num = v;
        en = v;
        ee = 0;
`endif
    endtask

    task automatic run_conv(input string nm, input logic [15:0] b, input int en, input bit ee);
        int   lat;
        logic busy0;
        logic moved;
        logic [13:0] n0;
        bcd     = b;
        convert = 1'b1;
        n0      = num;
        tick();
        convert = 1'b0;
        bcd     = 16'($urandom);
        busy0   = busy;
        lat     = 0;
        moved   = 1'b0;
        while (!conv_done && lat < 40) begin
            if (num !== n0) moved = 1'b1;
            tick();
            lat++;
        end
        chk({nm, " done"}, int'(conv_done), 1);
        chk({nm, " latency"}, lat, ee ? 0 : 14);
        chk({nm, " num"}, int'(num), en);
        chk({nm, " error"}, int'(error), int'(ee));
        chk({nm, " busy_at_e0"}, int'(busy0), ee ? 0 : 1);
        chk({nm, " busy_at_done"}, int'(busy), 0);
        chk({nm, " num_stable"}, int'(moved), 0);
        tick();
        chk({nm, " single_pulse"}, int'(conv_done), 0);
    endtask

    initial begin
        int   en;
        bit   ee;
        int   lat;
        int   ndone;
        int   first_lat;
        int   second_lat;
        logic [13:0] done_num;

        tab[0] = '{16'h1234, 14'd1234, 1'b0};
`ifdef BCD_INT_CHECK_EN
        tab[1] = '{16'h12A4, 14'd1234, 1'b1};
`else
        tab[1] = '{16'h12A4, 14'd1294, 1'b0};
`endif
        tab[2] = '{16'h0042, 14'd42,   1'b0};
        tab[3] = '{16'h9999, 14'd9999, 1'b0};
        tab[4] = '{16'h0000, 14'd0,    1'b0};
        tab[5] = '{16'h0001, 14'd1,    1'b0};
`ifdef BCD_INT_CHECK_EN
        tab[6] = '{16'hFFFF, 14'd1,    1'b1};
        tab[7] = '{16'h0FA0, 14'd1,    1'b1};
`else
        tab[6] = '{16'hFFFF, 14'd9999, 1'b0};
        tab[7] = '{16'h0FA0, 14'd990,  1'b0};
`endif

        rst     = 1'b1;
        convert = 1'b0;
        bcd     = 16'h0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset num", int'(num), 0);
        chk("reset conv_done", int'(conv_done), 0);
        chk("reset error", int'(error), 0);
        chk("reset busy", int'(busy), 0);

        for (int v = 0; v < 8; v++) begin
            run_conv($sformatf("tab%0d", v), tab[v].b, int'(tab[v].exp_num), tab[v].exp_err);
            model_num = int'(tab[v].exp_num);
        end

        // convert and bcd changes during CONV must be ignored
        bcd     = 16'h5000;
        convert = 1'b1;
        tick();
        convert = 1'b0;
        bcd     = 16'h0000;
        repeat (4) tick();
        bcd     = 16'h0007;
        convert = 1'b1;
        tick();
        convert   = 1'b0;
        bcd       = 16'h1234;
        lat       = 5;
        ndone     = 0;
        first_lat = -1;
        done_num  = '0;
        while (lat < 40) begin
            if (conv_done) begin
                ndone++;
                if (first_lat < 0) begin
                    first_lat = lat;
                    done_num  = num;
                end
            end
            tick();
            lat++;
        end
        chk("midrun done_count", ndone, 1);
        chk("midrun latency", first_lat, 14);
        chk("midrun num", int'(done_num), 5000);
        chk("midrun idle_after", int'(busy), 0);
        model_num = 5000;

        // reset during conversion aborts with no done pulse
        bcd     = 16'h8888;
        convert = 1'b1;
        tick();
        convert = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort busy", int'(busy), 0);
        chk("abort num", int'(num), 0);
        chk("abort conv_done", int'(conv_done), 0);
        chk("abort error", int'(error), 0);
        ndone = 0;
        repeat (20) begin
            if (conv_done) ndone++;
            tick();
        end
        chk("abort no_done", ndone, 0);
        run_conv("after_abort", 16'h0010, 10, 1'b0);
        model_num = 10;

        // convert held high: one conversion per 15 cycles
        bcd        = 16'h0321;
        convert    = 1'b1;
        tick();
        lat        = 0;
        ndone      = 0;
        first_lat  = -1;
        second_lat = -1;
        while (ndone < 2 && lat < 60) begin
            if (conv_done) begin
                ndone++;
                if (first_lat < 0) first_lat = lat;
                else second_lat = lat;
            end
            if (ndone < 2) begin
                tick();
                lat++;
            end
        end
        convert = 1'b0;
        chk("b2b first", first_lat, 14);
        chk("b2b second", second_lat, 29);
        chk("b2b num", int'(num), 321);
        model_num = 321;
        repeat (16) tick();
        chk("b2b stopped", int'(busy), 0);

        for (int r = 0; r < 30; r++) begin
            logic [15:0] b;
            b = 16'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                for (int k = 0; k < 4; k++) b[4*k +: 4] = 4'($urandom_range(0, 9));
            end
            model(b, en, ee);
            run_conv($sformatf("rand%0d_%h", r, b), b, en, ee);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
